// File: rtl/digi_ota_pkg.sv
// digi_ota_pkg: shared types and constants for the OTA offset-trim sequencer.
//   TRIM_W / TRIM_MID : trim code width and mid-scale starting code
//   SAMPLE_N          : comparator samples per trial (3 with DIGI_OTA_MAJORITY_EN, else 1)
//   ota_state_e       : sequencer states
//   maj3()            : 2-of-3 majority vote
package digi_ota_pkg;
  localparam int TRIM_W = 6;
  localparam logic [TRIM_W-1:0] TRIM_MID = 6'b100000;
`ifdef DIGI_OTA_MAJORITY_EN
  localparam int SAMPLE_N = 3;
`else
  localparam int SAMPLE_N = 1;
`endif

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DECIDE, ST_DONE
  } ota_state_e;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction
endpackage

// File: rtl/digi_ota_sync2.sv
// digi_ota_sync2: two-flop synchronizer for the asynchronous comparator output.
//   clk, rst_n : clock, async active-low reset (flops clear to 0)
//   d          : asynchronous input
//   q          : synchronized output, two cycles of latency
module digi_ota_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/digi_ota_trim_seq.sv
// digi_ota_trim_seq: successive-approximation offset-trim sequencer for an OTA.
// Each of the 6 trim bits takes N settle cycles, SAMPLE_N sample cycles and one
// decide cycle, so done pulses 6*(N+SAMPLE_N+1) cycles after start is accepted.
// Build option: DIGI_OTA_MAJORITY_EN -> 3-sample majority vote per trial.
//   clk, rst_n     : clock, async active-low reset
//   start, abort   : begin a run (IDLE only) / cancel a run (wins over start)
//   settle_cycles  : settle cycles per trial, 0 treated as 1
//   cmp_in         : asynchronous comparator, 1 means trim code too high
//   ota_en, trim   : OTA enable and trim code
//   busy, done     : not-IDLE flag, one-cycle completion pulse
//   result         : last completed trim code
module digi_ota_trim_seq
  import digi_ota_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [3:0]        settle_cycles,
  input  logic              cmp_in,
  output logic              ota_en,
  output logic [TRIM_W-1:0] trim,
  output logic              busy,
  output logic              done,
  output logic [TRIM_W-1:0] result
);
  localparam logic [3:0] SMP_LAST = 4'(SAMPLE_N - 1);

  ota_state_e        state, state_nx;
  logic              cmp_s;
  logic [3:0]        cnt, n_q;
  logic [2:0]        bidx;
  logic              sample;
  logic [TRIM_W-1:0] trim_dec;

  digi_ota_sync2 u_sync (.clk(clk), .rst_n(rst_n), .d(cmp_in), .q(cmp_s));

`ifdef DIGI_OTA_MAJORITY_EN
  logic [2:0] smp;
  assign sample = maj3(smp);
`else
  logic smp;
  assign sample = smp;
`endif

  // Resolve the current bit from the sample and arm the next lower bit.
  always_comb begin
    trim_dec = trim;
    if (sample) trim_dec[bidx] = 1'b0;
    if (bidx != 3'd0) trim_dec[bidx - 3'd1] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (start && !abort) state_nx = ST_SETTLE;
      ST_SETTLE: if (cnt == n_q - 4'd1) state_nx = ST_SAMPLE;
      ST_SAMPLE: if (cnt == SMP_LAST) state_nx = ST_DECIDE;
      ST_DECIDE: state_nx = (bidx == 3'd0) ? ST_DONE : ST_SETTLE;
      ST_DONE:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
    if (abort && state != ST_IDLE) state_nx = ST_IDLE;
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trim   <= TRIM_MID;
      result <= TRIM_MID;
      cnt    <= 4'd0;
      n_q    <= 4'd0;
      bidx   <= 3'd0;
      smp    <= '0;
      ota_en <= 1'b0;
    end else begin
      // Registered so the analog enable never glitches on state decode.
      ota_en <= (state_nx == ST_SETTLE) || (state_nx == ST_SAMPLE) ||
                (state_nx == ST_DECIDE);
      // Per-state dwell counter restarts on every state change.
      if (state_nx != state || state == ST_IDLE) cnt <= 4'd0;
      else                                       cnt <= cnt + 4'd1;

      if (abort && state != ST_IDLE) begin
        trim <= result;
      end else begin
        case (state)
          ST_IDLE: begin
            trim <= result;
            if (start) begin
              n_q  <= (settle_cycles == 4'd0) ? 4'd1 : settle_cycles;
              trim <= TRIM_MID;
              bidx <= 3'd5;
            end
          end
`ifdef DIGI_OTA_MAJORITY_EN
          ST_SAMPLE: smp <= {smp[1:0], cmp_s};
`else
          ST_SAMPLE: smp <= cmp_s;
`endif
          ST_DECIDE: begin
            trim <= trim_dec;
            if (bidx != 3'd0) bidx <= bidx - 3'd1;
          end
          ST_DONE: result <= trim;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_digi_ota_trim_seq.sv
module tb_digi_ota_trim_seq;
`ifdef DIGI_OTA_MAJORITY_EN
  localparam int S = 3;
`else
  localparam int S = 1;
`endif

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, glitch = 1'b0;
  logic [3:0] settle = 4'd4;
  logic cmp_in, ota_en, busy, done;
  logic [5:0] trim, result;
  int target = 0;

  typedef struct { int res; int cyc; } exp_t;
  exp_t q[$];
  exp_t e;
  int cyc = 0, acc = 0, n_tests = 0, n_fail = 0, n_done = 0;
  int res_exp = 0;
  bit res_pend = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // OTA model: comparator high when the trim code is above the target.
  assign cmp_in = (int'(trim) > target) ^ glitch;

  digi_ota_trim_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .settle_cycles(settle), .cmp_in(cmp_in), .ota_en(ota_en), .trim(trim),
    .busy(busy), .done(done), .result(result)
  );

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (res_pend) begin
      chk("result_reg", int'(result), res_exp);
      res_pend = 0;
    end
    if (rst_n && done) begin
      n_done++;
      if (q.size() == 0) chk("unexpected_done", int'(done), 0);
      else begin
        e = q.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("done_trim", int'(trim), e.res);
        res_pend = 1;
        res_exp  = e.res;
      end
    end
  end

  task automatic run(input int tgt, input logic [3:0] n, input int exp_res, input bit push);
    int ne;
    ne = (n == 4'd0) ? 1 : int'(n);
    @(negedge clk);
    target = tgt;
    settle = n;
    start  = 1'b1;
    acc    = cyc + 1;
    if (push) q.push_back('{exp_res, acc + 6 * (ne + S + 1)});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    int n0;
    bit seen;
    n0 = n_done;
    seen = 0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      #1;
      if (n_done > n0) seen = 1;
    end
    if (!seen) chk("done_timeout", n_done, n0 + 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_trim", int'(trim), 32);
    chk("rst_result", int'(result), 32);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ota_en", int'(ota_en), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Target 37, N=4, with start re-pulsed while busy.
    run(37, 4'd4, 37, 1);
    while (cyc < acc + 10) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    while (cyc < acc + 20) @(negedge clk);
    chk("run_busy", int'(busy), 1);
    chk("run_ota_en", int'(ota_en), 1);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_done(200);
    chk("idle_trim", int'(trim), 37);
    chk("idle_ota_en", int'(ota_en), 0);
    chk("idle_busy", int'(busy), 0);

    run(0,  4'd4,  0,  1); wait_done(200);
    run(63, 4'd0,  63, 1); wait_done(200);
    run(42, 4'd15, 42, 1); wait_done(200);
    run(20, 4'd4,  20, 1); wait_done(200);

    // Abort during the bit-3 settle phase.
    run(50, 4'd4, 0, 0);
    while (cyc < acc + 2 * (4 + S + 1) + 1) @(negedge clk);
    chk("pre_abort_busy", int'(busy), 1);
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_trim", int'(trim), 20);
    chk("abort_ota_en", int'(ota_en), 0);
    chk("abort_result", int'(result), 20);
    repeat (60) @(negedge clk);

    // Abort beats start in IDLE.
    start = 1'b1; abort = 1'b1; @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_prio_busy", int'(busy), 0);

    // Reset in the middle of a run.
    run(37, 4'd4, 0, 0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_trim", int'(trim), 32);
    chk("mrst_result", int'(result), 32);
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_ota_en", int'(ota_en), 0);
    chk("mrst_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("post_rst_busy", int'(busy), 0);

`ifdef DIGI_OTA_MAJORITY_EN
    // One-cycle inverted comparator glitch inside the bit-5 sample window.
    run(10, 4'd2, 10, 1);
    while (cyc < acc + 2) @(negedge clk);
    glitch = 1'b1; @(negedge clk); glitch = 1'b0;
    wait_done(200);
`endif

    chk("scoreboard_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
